// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl
// Reads the two words of an Avalon-MM sysid slave (ID at address 0, build
// timestamp at address 1) and compares them against the values this image
// was built with. A mismatch is re-read up to MAX_RETRIES times. A stalled
// read that exceeds TIMEOUT_CYCLES ends the check. Results are sticky until
// the next accepted start. Every output comes straight from a flop.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1553134383,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_ID = 3'd1,
        S_RD_TS = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic [3:0]  RETRY_LIM   = 4'(MAX_RETRIES);

    state_t      r_state;
    state_t      w_state_nxt;

    // Registered outputs and internal counters
    logic        r_avm_read;
    logic        r_avm_address;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic [3:0]  r_retry_cnt;
    logic [15:0] r_wait_cnt;

    // Next values for the registers above
    logic        w_avm_read_nxt;
    logic        w_avm_address_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_pass_nxt;
    logic        w_fail_nxt;
    logic        w_timeout_nxt;
    logic [31:0] w_id_value_nxt;
    logic [31:0] w_ts_value_nxt;
    logic [3:0]  w_retry_cnt_nxt;
    logic [15:0] w_wait_cnt_nxt;

    // Bus handshake decode
    logic        w_in_read;
    logic        w_accept;
    logic        w_expire;
    logic        w_match;
    logic [15:0] w_wait_inc;

    assign w_in_read  = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign w_accept   = w_in_read && !avm_waitrequest;
    assign w_wait_inc = r_wait_cnt + 16'd1;
    // The stall that brings the counter up to the limit is the last one allowed.
    assign w_expire   = w_in_read && avm_waitrequest && (w_wait_inc == TIMEOUT_LIM);
    assign w_match    = (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TS);

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RD_ID;
            end
            S_RD_ID: begin
                if (!avm_waitrequest) w_state_nxt = S_RD_TS;
                else if (w_expire)    w_state_nxt = S_DONE;
            end
            S_RD_TS: begin
                if (!avm_waitrequest) w_state_nxt = S_CHECK;
                else if (w_expire)    w_state_nxt = S_DONE;
            end
            S_CHECK: begin
                if (w_match)                       w_state_nxt = S_DONE;
                else if (r_retry_cnt < RETRY_LIM)  w_state_nxt = S_RD_ID;
                else                               w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values; bus strobes follow the state being entered
    always_comb begin
        w_avm_read_nxt    = (w_state_nxt == S_RD_ID) || (w_state_nxt == S_RD_TS);
        w_avm_address_nxt = (w_state_nxt == S_RD_TS);
        w_busy_nxt        = (w_state_nxt == S_RD_ID) || (w_state_nxt == S_RD_TS)
                         || (w_state_nxt == S_CHECK);
        w_done_nxt        = (r_state == S_DONE);
        w_pass_nxt        = r_pass;
        w_fail_nxt        = r_fail;
        w_timeout_nxt     = r_timeout;
        w_id_value_nxt    = r_id_value;
        w_ts_value_nxt    = r_ts_value;
        w_retry_cnt_nxt   = r_retry_cnt;
        w_wait_cnt_nxt    = r_wait_cnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pass_nxt      = 1'b0;
                    w_fail_nxt      = 1'b0;
                    w_timeout_nxt   = 1'b0;
                    w_retry_cnt_nxt = 4'd0;
                    w_wait_cnt_nxt  = 16'd0;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (w_accept) begin
                    w_wait_cnt_nxt = 16'd0;
                    if (r_state == S_RD_ID) w_id_value_nxt = avm_readdata;
                    else                    w_ts_value_nxt = avm_readdata;
                end else begin
                    w_wait_cnt_nxt = w_wait_inc;
                    if (w_expire) w_timeout_nxt = 1'b1;
                end
            end
            S_CHECK: begin
                if (w_match)                      w_pass_nxt      = 1'b1;
                else if (r_retry_cnt < RETRY_LIM) w_retry_cnt_nxt = r_retry_cnt + 4'd1;
                else                              w_fail_nxt      = 1'b1;
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_avm_read    <= 1'b0;
            r_avm_address <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_id_value    <= 32'd0;
            r_ts_value    <= 32'd0;
            r_retry_cnt   <= 4'd0;
            r_wait_cnt    <= 16'd0;
        end else begin
            r_avm_read    <= w_avm_read_nxt;
            r_avm_address <= w_avm_address_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_pass        <= w_pass_nxt;
            r_fail        <= w_fail_nxt;
            r_timeout     <= w_timeout_nxt;
            r_id_value    <= w_id_value_nxt;
            r_ts_value    <= w_ts_value_nxt;
            r_retry_cnt   <= w_retry_cnt_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    assign avm_read    = r_avm_read;
    assign avm_address = r_avm_address;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Testbench for sysid_check_ctrl: a behavioural sysid slave with
// programmable wrong data and wait states, a table of complete checks,
// and hand-written sequences for reset and ignored starts.
module tb_sysid_check_ctrl;

    localparam logic [31:0] GOOD_ID = 32'd0;
    localparam logic [31:0] BAD_ID  = 32'd1;
    localparam logic [31:0] GOOD_TS = 32'd1553134383;
    localparam logic [31:0] BAD_TS  = 32'd1553134382;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy, done, pass, fail, timeout;
    logic [31:0] id_value, ts_value;

    int n_cmp = 0;
    int n_err = 0;

    // Slave model controls (written only by the stimulus process)
    int  cfg_bad_ts_n = 0;     // number of wrong timestamp reads before good ones
    bit  cfg_bad_id = 1'b0;
    int  cfg_stall_n = 0;      // stalled cycles per read
    bit  cfg_stall_forever = 1'b0;
    int  ts_base = 0;

    // Slave model state (written only by the always blocks)
    int  stall_cnt = 0;
    int  n_id_rd = 0;
    int  n_ts_rd = 0;
    int  stab_err = 0;
    bit  prev_stalled = 1'b0;
    logic prev_addr = 1'b0;

    sysid_check_ctrl #(
        .EXPECTED_ID    (GOOD_ID),
        .EXPECTED_TS    (GOOD_TS),
        .MAX_RETRIES    (3),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail            (fail),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    assign avm_waitrequest = avm_read && (cfg_stall_forever || (stall_cnt < cfg_stall_n));
    assign avm_readdata = avm_address ? (((n_ts_rd - ts_base) < cfg_bad_ts_n) ? BAD_TS : GOOD_TS)
                                      : (cfg_bad_id ? BAD_ID : GOOD_ID);

    // Slave: stall counting and accepted-read bookkeeping
    always @(posedge clock) begin
        if (!avm_read) stall_cnt <= 0;
        else if (avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else begin
            stall_cnt <= 0;
            if (avm_address) n_ts_rd <= n_ts_rd + 1;
            else             n_id_rd <= n_id_rd + 1;
        end
    end

    // Bus rule: read and address hold while the slave stalls (timeout may drop read)
    always @(negedge clock) begin
        if (prev_stalled && reset_n && !timeout && (!avm_read || avm_address != prev_addr))
            stab_err <= stab_err + 1;
        prev_stalled <= avm_read && avm_waitrequest;
        prev_addr    <= avm_address;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start from a negedge; return the number of rising edges from the
    // one that samples start up to the one after which done is seen.
    task automatic run_check(output int cyc);
        bit seen;
        seen = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 1;
        while (!seen && cyc < 100) begin
            @(negedge clock);
            if (done) seen = 1'b1;
            else begin
                @(posedge clock);
                cyc++;
            end
        end
        if (!seen) begin
            $display("FAIL done_wait: no done within %0d cycles", cyc);
            n_err++;
            n_cmp++;
            cyc = -1;
        end
    endtask

    typedef struct {
        string       name;
        int          bad_ts_n;
        bit          bad_id;
        int          stall_n;
        bit          stall_forever;
        int          exp_cyc;
        bit          exp_pass;
        bit          exp_fail;
        bit          exp_to;
        int          exp_id_rd;
        int          exp_ts_rd;
        logic [31:0] exp_id;
        logic [31:0] exp_ts;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cyc, id0, ts0, dones, done_at;
        bit hit;

        vecs[0] = '{"good_zero_wait",   0, 1'b0, 0, 1'b0,  5, 1'b1, 1'b0, 1'b0, 1, 1, GOOD_ID, GOOD_TS};
        vecs[1] = '{"bad_ts_all",     100, 1'b0, 0, 1'b0, 14, 1'b0, 1'b1, 1'b0, 4, 4, GOOD_ID, BAD_TS};
        vecs[2] = '{"bad_ts_once",      1, 1'b0, 0, 1'b0,  8, 1'b1, 1'b0, 1'b0, 2, 2, GOOD_ID, GOOD_TS};
        vecs[3] = '{"stall_forever",    0, 1'b0, 0, 1'b1, 12, 1'b0, 1'b0, 1'b1, 0, 0, GOOD_ID, GOOD_TS};
        vecs[4] = '{"stall_3",          0, 1'b0, 3, 1'b0, 11, 1'b1, 1'b0, 1'b0, 1, 1, GOOD_ID, GOOD_TS};
        vecs[5] = '{"stall_9_edge",     0, 1'b0, 9, 1'b0, 23, 1'b1, 1'b0, 1'b0, 1, 1, GOOD_ID, GOOD_TS};
        vecs[6] = '{"bad_id_all",       0, 1'b1, 0, 1'b0, 14, 1'b0, 1'b1, 1'b0, 4, 4, BAD_ID,  GOOD_TS};
        vecs[7] = '{"stall_2_bad_once", 1, 1'b0, 2, 1'b0, 16, 1'b1, 1'b0, 1'b0, 2, 2, GOOD_ID, GOOD_TS};

        // Reset state, asserted from time zero
        #3;
        check("reset_ctrl", 64'({avm_read, avm_address, busy, done, pass, fail, timeout}), 64'd0);
        check("reset_data", {id_value, ts_value}, 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_no_read", 64'({avm_read, busy}), 64'd0);

        // Table of complete checks
        for (int i = 0; i < 8; i++) begin
            cfg_bad_ts_n      = vecs[i].bad_ts_n;
            cfg_bad_id        = vecs[i].bad_id;
            cfg_stall_n       = vecs[i].stall_n;
            cfg_stall_forever = vecs[i].stall_forever;
            ts_base           = n_ts_rd;
            id0               = n_id_rd;
            ts0               = n_ts_rd;
            run_check(cyc);
            check({vecs[i].name, "_latency"}, 64'(cyc), 64'(vecs[i].exp_cyc));
            check({vecs[i].name, "_flags"}, 64'({pass, fail, timeout}),
                  64'({vecs[i].exp_pass, vecs[i].exp_fail, vecs[i].exp_to}));
            check({vecs[i].name, "_id_reads"}, 64'(n_id_rd - id0), 64'(vecs[i].exp_id_rd));
            check({vecs[i].name, "_ts_reads"}, 64'(n_ts_rd - ts0), 64'(vecs[i].exp_ts_rd));
            check({vecs[i].name, "_values"}, {id_value, ts_value}, {vecs[i].exp_id, vecs[i].exp_ts});
            check({vecs[i].name, "_bus_idle"}, 64'({avm_read, busy}), 64'd0);
            @(negedge clock);
            check({vecs[i].name, "_done_width"}, 64'(done), 64'd0);
            check({vecs[i].name, "_flags_hold"}, 64'({pass, fail, timeout}),
                  64'({vecs[i].exp_pass, vecs[i].exp_fail, vecs[i].exp_to}));
            cfg_stall_forever = 1'b0;
            repeat (2) @(negedge clock);
        end
        check("stall_stability", 64'(stab_err), 64'd0);

        // Extra starts while busy and in DONE are ignored
        cfg_bad_ts_n = 0; cfg_bad_id = 1'b0; cfg_stall_n = 3; ts_base = n_ts_rd;
        id0 = n_id_rd; ts0 = n_ts_rd; dones = 0; done_at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done) begin
                dones++;
                if (done_at < 0) done_at = i;
            end
            start = (i == 0) || (i == 3) || (i == 6) || (i == 10);
        end
        start = 1'b0;
        check("ignored_start_latency", 64'(done_at), 64'd11);
        check("ignored_start_done_count", 64'(dones), 64'd1);
        check("ignored_start_reads", 64'({16'(n_id_rd - id0), 16'(n_ts_rd - ts0)}), 64'h0001_0001);
        check("ignored_start_result", 64'({busy, pass, fail, timeout}), 64'b0100);
        check("ignored_start_stability", 64'(stab_err), 64'd0);

        // Reset during RD_TS aborts at once; nothing runs afterwards
        cfg_stall_n = 0; cfg_bad_id = 1'b1;
        id0 = n_id_rd; ts0 = n_ts_rd;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clock);
            if (avm_read && avm_address) hit = 1'b1;
        end
        check("reached_rd_ts", 64'(hit), 64'd1);
        check("rd_ts_id_captured", 64'(id_value), 64'(BAD_ID));
        reset_n = 1'b0;
        #1;
        check("midreset_ctrl", 64'({avm_read, avm_address, busy, done, pass, fail, timeout}), 64'd0);
        check("midreset_data", {id_value, ts_value}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("post_reset_idle", 64'({avm_read, busy, done, pass, fail, timeout}), 64'd0);
        check("post_reset_reads", 64'({16'(n_id_rd - id0), 16'(n_ts_rd - ts0)}), 64'h0001_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sysid_check_ctrl.md
SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd0: system ID value expected at sysid word 0.
REQ-002 Parameter EXPECTED_TS, default 32'd1553134383: timestamp value expected at sysid word 1.
REQ-003 Parameter MAX_RETRIES, default 3, range 0..15: re-read attempts after a mismatch.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, range 1..65535: cycle limit per read while waitrequest is high.
REQ-005 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port start, input, 1: one-cycle request to run a check.
REQ-008 Port avm_address, output, 1: word select to the sysid slave (0 = ID, 1 = timestamp).
REQ-009 Port avm_read, output, 1: Avalon-MM read strobe.
REQ-010 Port avm_readdata, input, 32: slave read data, valid in the cycle avm_read=1 and avm_waitrequest=0.
REQ-011 Port avm_waitrequest, input, 1: slave stall; tie to 0 for a zero-wait slave.
REQ-012 Port busy, output, 1: high while a check is in progress.
REQ-013 Port done, output, 1: one-cycle pulse at completion.
REQ-014 Port pass, output, 1: sticky result, ID and timestamp matched.
REQ-015 Port fail, output, 1: sticky result, mismatch after all retries.
REQ-016 Port timeout, output, 1: sticky result, read stalled past TIMEOUT_CYCLES.
REQ-017 Port id_value, output, 32: last captured ID word.
REQ-018 Port ts_value, output, 32: last captured timestamp word.

Function
REQ-019 FSM states SHALL be IDLE, RD_ID, RD_TS, CHECK and DONE; all outputs are registered.
REQ-020 IDLE: busy=0, avm_read=0; start=1 SHALL clear pass, fail, timeout, retry count and wait counter, then go to RD_ID.
REQ-021 RD_ID: avm_read=1, avm_address=0, busy=1; when waitrequest=0, SHALL capture avm_readdata into id_value and go to RD_TS.
REQ-022 RD_TS: avm_read=1, avm_address=1; when waitrequest=0, SHALL capture avm_readdata into ts_value and go to CHECK.
REQ-023 avm_read and avm_address SHALL stay constant while waitrequest=1; avm_read SHALL drop in the cycle after acceptance unless the next state reads again.
REQ-024 Wait counter (16 bit) SHALL increment each RD_* cycle with waitrequest=1 and clear on each accepted read; on reaching TIMEOUT_CYCLES, SHALL set timeout, deassert avm_read and go to DONE.
REQ-025 CHECK: if id_value==EXPECTED_ID and ts_value==EXPECTED_TS, SHALL set pass and go to DONE.
REQ-026 CHECK, mismatch with retry count < MAX_RETRIES: SHALL increment the retry count and go to RD_ID.
REQ-027 CHECK, mismatch with retry count == MAX_RETRIES: SHALL set fail and go to DONE.
REQ-028 DONE: done=1 for exactly one cycle, busy=0, then IDLE; pass/fail/timeout SHALL hold until the next accepted start.
REQ-029 Exactly one of pass/fail/timeout SHALL be set after any completed check.
REQ-030 start while busy=1 or in DONE SHALL be ignored, with no effect on state or counters.
REQ-031 With waitrequest=0, latency SHALL be start sampled at edge N -> done=1 in the cycle after edge N+4 (IDLE, RD_ID, RD_TS, CHECK, DONE).
REQ-032 Each retry SHALL add 3 cycles (RD_ID, RD_TS, CHECK) with zero waits.

Reset
REQ-033 reset_n=0 SHALL asynchronously force IDLE with avm_read, avm_address, busy, done, pass, fail, timeout, id_value, ts_value, retry count and wait counter all 0.
REQ-034 Reset asserted mid-transaction SHALL abort the read immediately; after release, no check SHALL run without a new start.

Verification
REQ-035 Zero-wait slave returning 0 at address 0 and 1553134383 at address 1, start pulse -> done exactly 5 cycles after start, pass=1, id_value=0, ts_value=1553134383.
REQ-036 Slave returns 1553134382 at address 1 with MAX_RETRIES=3 -> 4 RD_ID/RD_TS pairs on the bus, then fail=1, pass=0, done pulse.
REQ-037 Wrong timestamp on first pass, correct on second -> exactly 2 read pairs, then pass=1.
REQ-038 waitrequest held high with TIMEOUT_CYCLES=10 -> timeout=1 after 10 stalled cycles in RD_ID, avm_read=0, done pulse.
REQ-039 waitrequest high 3 cycles per read -> address/read stable while stalled, pass=1, done 11 cycles after start.
REQ-040 reset_n low during RD_TS, extra start pulses while busy -> immediate IDLE with all outputs 0; ignored starts cause no extra bus reads.
